// File: rtl/dmem_lsu.sv
`default_nettype none
// =============================================================================
// dmem_lsu : load/store unit for a single-port, word-wide data memory with
//            registered reads; sub-word stores use read-modify-write.
// Revision : 1.0
// =============================================================================
module dmem_lsu #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
);

  localparam logic [1:0] C_SZ_BYTE = 2'b00;
  localparam logic [1:0] C_SZ_HALF = 2'b01;
  localparam logic [1:0] C_SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CAP  = 3'd2,
    S_WR   = 3'd3,
    S_RESP = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic              r_we;
  logic [1:0]        r_size;
  logic              r_signed;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_wbuf;

  logic              w_accept;
  logic              w_req_err;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [DATA_W-1:0] w_load_val;
  logic [DATA_W-1:0] w_merge;

  assign w_accept = req_valid & req_ready;

  always_comb begin
    w_req_err = 1'b0;
    case (req_size)
      C_SZ_BYTE: w_req_err = 1'b0;
      C_SZ_HALF: w_req_err = req_addr[0];
      C_SZ_WORD: w_req_err = (req_addr[1:0] != 2'b00);
      default:   w_req_err = 1'b1;
    endcase
  end

  // Lane extraction and merge both operate on the registered read word.
  always_comb begin
    w_byte     = mem_rd[{r_addr[1:0], 3'b000} +: 8];
    w_half     = r_addr[1] ? mem_rd[31:16] : mem_rd[15:0];
    w_load_val = mem_rd;
    case (r_size)
      C_SZ_BYTE: w_load_val = {{24{r_signed & w_byte[7]}}, w_byte};
      C_SZ_HALF: w_load_val = {{16{r_signed & w_half[15]}}, w_half};
      default:   w_load_val = mem_rd;
    endcase
  end

  always_comb begin
    w_merge = mem_rd;
    if (r_size == C_SZ_BYTE) begin
      w_merge[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
    end else begin
      w_merge[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_req_err) begin
            w_state_nxt = S_RESP;
          end else if (req_we && (req_size == C_SZ_WORD)) begin
            w_state_nxt = S_WR;
          end else begin
            w_state_nxt = S_RD;
          end
        end
      end
      S_RD:    w_state_nxt = S_CAP;
      S_CAP:   w_state_nxt = r_we ? S_WR : S_RESP;
      S_WR:    w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we     <= 1'b0;
      r_size   <= 2'b00;
      r_signed <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
    end else if (w_accept) begin
      r_we     <= req_we;
      r_size   <= req_size;
      r_signed <= req_signed;
      r_addr   <= req_addr;
      r_wdata  <= req_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wbuf <= '0;
    end else if ((r_state == S_CAP) && r_we) begin
      r_wbuf <= w_merge;
    end
  end

  // Response fields change only on the way into RESP and hold afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else if ((r_state == S_IDLE) && w_accept && w_req_err) begin
      resp_err   <= 1'b1;
      resp_rdata <= '0;
    end else if ((r_state == S_CAP) && !r_we) begin
      resp_err   <= 1'b0;
      resp_rdata <= w_load_val;
    end else if (r_state == S_WR) begin
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end
  end

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = (r_state == S_RESP);
  assign mem_we     = (r_state == S_WR);
  assign mem_a      = {r_addr[ADDR_W-1:2], 2'b00};
  assign mem_wd     = (r_state != S_WR)       ? '0      :
                      (r_size == C_SZ_WORD)   ? r_wdata : r_wbuf;

endmodule
`default_nettype wire
